// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   MULT_WIDTH   : default operand width
//   MULT_CNT_W   : iteration counter width for MULT_WIDTH
//   mult_state_t : control FSM states
package mult_pkg;
  localparam int MULT_WIDTH = 8;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;
endpackage

// File: rtl/seq_mult_dp.sv
// Datapath for seq_multiplier: operand capture, masked partial product,
// accumulate and shift.
//   clk, rst  : clock, async active-high reset
//   load_i    : capture a_i/b_i and clear the accumulator
//   step_i    : perform one multiply iteration
//   a_i, b_i  : multiplicand / multiplier
//   acc_nxt_o : accumulator value after the current iteration (what the
//               next edge will store when step_i is high)
module seq_mult_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_nxt_o
);
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     sum;

  // Partial product is the multiplicand gated by the current multiplier bit.
  assign pp  = a_q & {WIDTH{mq_q[0]}};
  assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, pp};
  // {carry, hi, lo} >> 1: carry lands in the accumulator MSB, lo's LSB drops.
  assign acc_nxt_o = {sum, acc_q[WIDTH-1:1]};

  always_comb begin
    a_d   = a_q;
    mq_d  = mq_q;
    acc_d = acc_q;
    if (load_i) begin
      a_d   = a_i;
      mq_d  = b_i;
      acc_d = '0;
    end else if (step_i) begin
      mq_d  = mq_q >> 1;
      acc_d = acc_nxt_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      mq_q  <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      mq_q  <= mq_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier, one partial product per cycle.
//   clk, rst : clock, async active-high reset
//   start    : request, accepted in IDLE or DONE
//   a, b     : unsigned operands, sampled on the accepting edge
//   busy     : high while iterating
//   done     : one-cycle pulse, product just updated
//   product  : registered result, held until the next completion
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  mult_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               load, step, last;

  seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .step_i    (step),
    .a_i       (a),
    .b_i       (b),
    .acc_nxt_o (acc_nxt)
  );

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // start is ignored here; operands in flight stay untouched.
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) begin
          // Final accumulate and product write share the same edge.
          product_d = acc_nxt;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign product = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected product.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else                   chk("product", 32'(product), 32'(exp_q.pop_front()));
    end
  end

  // Drive start for one edge; caller guarantees DUT is IDLE or DONE.
  task automatic start_op(input int x, input int y);
    start = 1'b1; a = W'(x); b = W'(y);
    exp_q.push_back((2*W)'(x * y));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count negedges until done (returns index); counts busy cycles on the way.
  task automatic wait_done(output int n, output int nbusy);
    n = 0; nbusy = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin n = i; return; end
      if (busy) nbusy++;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n, nb, extra;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 13 x 11: latency and busy duration.
    start_op(13, 11);
    wait_done(n, nb);
    chk("lat_13x11", 32'(n), 32'd9);
    chk("busy_13x11", 32'(nb), 32'd8);
    chk("busy_in_done", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("hold_143", 32'(product), 32'd143);
    chk("idle_busy", 32'(busy), 32'd0);

    // Carry into the accumulator MSB.
    @(posedge clk); #1;
    start_op(255, 255);
    wait_done(n, nb);
    chk("val_ff_ff", 32'(product), 32'hFE01);

    // Zero operands on either side.
    @(posedge clk); #1;
    start_op(0, 200);
    wait_done(n, nb);
    chk("lat_0x200", 32'(n), 32'd9);
    @(posedge clk); #1;
    start_op(200, 0);
    wait_done(n, nb);
    chk("lat_200x0", 32'(n), 32'd9);

    // start during RUN is ignored.
    @(posedge clk); #1;
    start_op(6, 7);
    @(posedge clk); @(posedge clk); #1;
    start = 1'b1; a = 8'd9; b = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, nb);
    chk("val_6x7", 32'(product), 32'd42);
    extra = 0;
    repeat (15) begin @(negedge clk); if (done) extra++; end
    chk("no_extra_done", 32'(extra), 32'd0);
    chk("hold_42", 32'(product), 32'd42);

    // Back-to-back: start held in the DONE cycle.
    @(posedge clk); #1;
    start_op(3, 5);
    wait_done(n, nb);
    chk("val_3x5", 32'(product), 32'd15);
    start = 1'b1; a = 8'd100; b = 8'd2;
    exp_q.push_back(16'd200);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, nb);
    chk("b2b_lat", 32'(n), 32'd9);
    chk("b2b_busy", 32'(nb), 32'd8);
    chk("val_100x2", 32'(product), 32'd200);

    // Async reset mid-RUN.
    @(posedge clk); #1;
    start_op(200, 3);
    @(posedge clk); @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    exp_q.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    start_op(4, 4);
    wait_done(n, nb);
    chk("lat_4x4", 32'(n), 32'd9);
    chk("val_4x4", 32'(product), 32'd16);
    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential unsigned shift-and-add multiplier for the Arithmetic/Multiplier path. Each cycle it forms one masked partial product (multiplicand AND-ed with the current multiplier bit), adds it into an accumulator and shifts. A `start`/`done` handshake frames each operation, and the product is registered and held until the next result. The block is the control and accumulate stage that drives the per-bit mask cell and consumes its output.

## Interface
- `WIDTH`, default 8: operand width; product is 2·WIDTH bits.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled on `clk` rising edge.
- `a`  in  WIDTH  multiplicand (unsigned), captured when `start` is accepted.
- `b`  in  WIDTH  multiplier (unsigned), captured when `start` is accepted.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse: `product` has just been updated.
- `product`  out  2·WIDTH  registered result; holds its value until the next completion.

## Operation
- Reset (async, `rst`=1): state=IDLE; `busy`=0, `done`=0, `product`=0; internal registers cleared.
- Internal registers:
  - `a_reg` (WIDTH): captured multiplicand.
  - `mq` (WIDTH): multiplier shift register.
  - `acc` (2·WIDTH): accumulator.
  - `cnt` (log2(WIDTH)+1 bits): iteration counter.
- FSM states: IDLE, RUN, DONE.
  - IDLE: `start`=1 → load `a_reg`=a, `mq`=b, `acc`=0, `cnt`=0; go to RUN. Otherwise stay.
  - RUN, each cycle:
    - pp = `a_reg` AND {WIDTH{`mq`[0]}}.
    - {c, hi} = `acc`[2W-1:W] + pp, a (WIDTH+1)-bit sum.
    - `acc` ← {c, hi, `acc`[W-1:0]} >> 1.
    - `mq` ← `mq` >> 1; `cnt`++.
    - When `cnt`=WIDTH-1 (last iteration): write the final `acc` value into `product` on the same edge, then go to DONE.
  - DONE: `done`=1 for exactly this cycle.
    - `start`=1 → accept a new operation (same load as IDLE) and go to RUN.
    - Otherwise go to IDLE.
- `start` in RUN is ignored; no queuing, and the operands in flight are unaffected.
- `busy` = (state==RUN).
- Arithmetic:
  - Unsigned only; no overflow is possible (2·WIDTH-bit result).
  - The carry out of the WIDTH-bit add is never lost; it enters the accumulator MSB on the shift.
- `a`/`b` are only sampled on the accepting edge; changes afterwards have no effect.

## Timing
- Take `start` sampled high in IDLE at edge k.
  - `busy` is high after edges k … k+WIDTH-1 (WIDTH cycles).
  - `product` updates at edge k+WIDTH.
  - `done` is high in the cycle following edge k+WIDTH.
- Latency from the accepting edge to `done`: WIDTH+1 edges.
- Back-to-back throughput: one result per WIDTH+1 cycles, with `start` held in the DONE cycle.
- `product` is stable from the completion edge until the next completion, including through IDLE and subsequent RUN phases.
- `rst` mid-RUN:
  - Immediate abort; all outputs 0, including `product`.
  - No `done` pulse; the first `start` after deassertion behaves as from IDLE.
- `start` coincident with `rst` deassertion edge: accepted only if sampled high on a rising `clk` edge while `rst`=0.

## Structure
- Shared package `mult_pkg`:
  - `MULT_WIDTH` = 8.
  - State enum `mult_state_t` {IDLE, RUN, DONE}.
  - Counter width constant `MULT_CNT_W` = $clog2(MULT_WIDTH)+1.
- One sub-module `seq_mult_dp`: datapath holding `a_reg`, `mq`, `acc`, the pp mask/add and the shift. The top holds the FSM, counter and `product`/`done` registers.

## Test plan
- `a`=13, `b`=11, single `start` pulse → `busy` for 8 cycles; `done` pulse 9 edges after acceptance; `product`=143 (0x008F).
- `a`=255, `b`=255 → `product`=65025 (0xFE01); verifies carry into the accumulator MSB.
- `a`=0, `b`=200, then `a`=200, `b`=0 → `product`=0 both times; `done` pulses normally.
- Start 6×7. Pulse `start` with `a`=9, `b`=9 on the 3rd RUN cycle → it is ignored; `product`=42, and no second `done` follows.
- Start 3×5. Hold `start` in the DONE cycle with 100×2 → `product`=15 with `done`, then `product`=200 with `done` exactly 9 cycles later; `busy` is low only during the DONE cycle.
- Start 200×3. Assert `rst` asynchronously mid-RUN (between clock edges) → `busy`, `done` and `product` go to 0 immediately; after release, 4×4 → `product`=16.
